// File: rtl/lc3_pkg.sv
// Shared types and constants for the LC-3 memory access unit.
// MMIO register map, bus width and FSM state encoding.
package lc3_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    MEM,
    DONE,
    RELEASE
  } state_t;

  localparam word_t KBSR_ADDR = 16'hFE00;
  localparam word_t KBDR_ADDR = 16'hFE02;
  localparam word_t DSR_ADDR  = 16'hFE04;
  localparam word_t DDR_ADDR  = 16'hFE06;

  typedef struct packed {
    logic kbsr;
    logic kbdr;
    logic dsr;
    logic ddr;
  } mmio_sel_t;

endpackage

// File: rtl/lc3_mem_ctrl_if.sv
// Memory-side req/rdy bus of the LC-3 access unit.
// master = access unit, slave = memory.
interface lc3_mem_ctrl_if;
  import lc3_pkg::*;

  logic  mem_req;
  logic  mem_we;
  word_t mem_addr;
  word_t mem_wdata;
  word_t mem_rdata;
  logic  mem_rdy;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_rdy
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_rdy
  );

endinterface

// File: rtl/lc3_mmio_dec.sv
// MAR decode for keyboard/display registers.
// Gives hit/select lines and the MMIO read-data mux.
module lc3_mmio_dec
  import lc3_pkg::*;
#(
  parameter bit MMIO_EN = 1'b1
) (
  input  word_t       addr,
  input  logic        kbd_valid,
  input  logic [7:0]  kbd_data,
  input  logic        dsp_rdy,
  output logic        hit,
  output logic        is_kbdr,
  output logic        is_ddr,
  output word_t       rdata
);

  mmio_sel_t sel;

  always_comb begin
    sel = '0;
    if (MMIO_EN) begin
      sel.kbsr = (addr == KBSR_ADDR);
      sel.kbdr = (addr == KBDR_ADDR);
      sel.dsr  = (addr == DSR_ADDR);
      sel.ddr  = (addr == DDR_ADDR);
    end
    hit     = |sel;
    is_kbdr = sel.kbdr;
    is_ddr  = sel.ddr;
    rdata   = '0;
    unique case (1'b1)
      sel.kbsr: rdata = {kbd_valid, 15'b0};
      sel.kbdr: rdata = {8'b0, kbd_data};
      sel.dsr:  rdata = {dsp_rdy, 15'b0};
      default:  rdata = '0;
    endcase
  end

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 MAR/MDR and memory/MMIO access sequencer.
// One access per mio_en request, R pulse on completion.
module lc3_mem_ctrl
  import lc3_pkg::*;
#(
  parameter bit MMIO_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_mar,
  input  logic                  ld_mdr,
  input  logic                  mio_en,
  input  logic                  r_w,
  input  word_t                 bus_in,
  output word_t                 mar_out,
  output word_t                 mdr_out,
  output logic                  r,
  lc3_mem_ctrl_if.master        mem,
  input  logic                  kbd_valid,
  input  logic [7:0]            kbd_data,
  output logic                  kbd_ack,
  input  logic                  dsp_rdy,
  output logic                  ddr_wr,
  output logic [7:0]            ddr_data
);

  state_t state;
  state_t state_nx;
  word_t  mar;
  word_t  mdr;
  logic   wr_q;

  logic   hit;
  logic   is_kbdr;
  logic   is_ddr;
  word_t  mmio_rdata;

  lc3_mmio_dec #(
    .MMIO_EN (MMIO_EN)
  ) u_dec (
    .addr      (mar),
    .kbd_valid (kbd_valid),
    .kbd_data  (kbd_data),
    .dsp_rdy   (dsp_rdy),
    .hit       (hit),
    .is_kbdr   (is_kbdr),
    .is_ddr    (is_ddr),
    .rdata     (mmio_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (mio_en) state_nx = hit ? DONE : MEM;
      MEM:     if (mem.mem_rdy) state_nx = DONE;
      DONE:    state_nx = RELEASE;
      RELEASE: if (!mio_en) state_nx = IDLE;
    endcase
  end

  // MAR/MDR only move in IDLE or on read completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mar  <= '0;
      mdr  <= '0;
      wr_q <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (ld_mar) mar <= bus_in;
        if (mio_en) begin
          wr_q <= r_w;
          if (hit && !r_w) mdr <= mmio_rdata;
        end else if (ld_mdr) begin
          mdr <= bus_in;
        end
      end
      if (state == MEM && mem.mem_rdy && !wr_q) begin
        mdr <= mem.mem_rdata;
      end
    end
  end

  assign mem.mem_req   = (state == MEM);
  assign mem.mem_we    = (state == MEM) && wr_q;
  assign mem.mem_addr  = mar;
  assign mem.mem_wdata = mdr;

  assign r        = (state == DONE);
  assign kbd_ack  = r && !wr_q && is_kbdr;
  assign ddr_wr   = r && wr_q && is_ddr;
  assign ddr_data = mdr[7:0];
  assign mar_out  = mar;
  assign mdr_out  = mdr;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Bench for lc3_mem_ctrl: randomized accesses against a
// transaction-level model, plus directed literal checks.
module tb_lc3_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ld_mar, ld_mdr, mio_en, r_w;
  logic [15:0] bus_in;
  logic [15:0] mar_out, mdr_out;
  logic        r;
  logic        kbd_valid;
  logic [7:0]  kbd_data;
  logic        kbd_ack;
  logic        dsp_rdy;
  logic        ddr_wr;
  logic [7:0]  ddr_data;

  logic        ld_mar1, ld_mdr1, mio1, rw1;
  logic [15:0] bus1;
  logic [15:0] mar1, mdr1;
  logic        r1, kack1, ddr_wr1;
  logic [7:0]  ddr_data1;

  lc3_mem_ctrl_if m0();
  lc3_mem_ctrl_if m1();

  lc3_mem_ctrl #(.MMIO_EN(1'b1)) u0 (
    .clk(clk), .rst(rst), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
    .mio_en(mio_en), .r_w(r_w), .bus_in(bus_in),
    .mar_out(mar_out), .mdr_out(mdr_out), .r(r), .mem(m0),
    .kbd_valid(kbd_valid), .kbd_data(kbd_data), .kbd_ack(kbd_ack),
    .dsp_rdy(dsp_rdy), .ddr_wr(ddr_wr), .ddr_data(ddr_data)
  );

  lc3_mem_ctrl #(.MMIO_EN(1'b0)) u1 (
    .clk(clk), .rst(rst), .ld_mar(ld_mar1), .ld_mdr(ld_mdr1),
    .mio_en(mio1), .r_w(rw1), .bus_in(bus1),
    .mar_out(mar1), .mdr_out(mdr1), .r(r1), .mem(m1),
    .kbd_valid(kbd_valid), .kbd_data(kbd_data), .kbd_ack(kack1),
    .dsp_rdy(dsp_rdy), .ddr_wr(ddr_wr1), .ddr_data(ddr_data1)
  );

  int vectors = 0;
  int miscompares = 0;
  int printed = 0;
  int cyc = 0;

  logic [15:0] model_mar, model_mdr;
  logic        p_mar_v, p_mdr_v;
  logic [15:0] p_mar, p_mdr;

  logic        t_act, t_mmio, t_wr;
  logic [15:0] t_addr;
  int          t_n, t_e, t_k;

  logic [15:0] mem_model [logic [15:0]];

  int          obs_req, obs_r, obs_r_cyc, obs_kack, obs_ddr;
  logic [7:0]  cap_ddr;
  logic [15:0] cap_addr, cap_wdata;
  logic        cap_we;

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (printed < 40)
        $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
      printed++;
    end
  endtask

  function automatic logic is_mmio(input logic [15:0] a);
    return (a == 16'hFE00) || (a == 16'hFE02) ||
           (a == 16'hFE04) || (a == 16'hFE06);
  endfunction

  function automatic logic [15:0] mmio_rd(input logic [15:0] a);
    case (a)
      16'hFE00: return {kbd_valid, 15'b0};
      16'hFE02: return {8'h00, kbd_data};
      16'hFE04: return {dsp_rdy, 15'b0};
      default:  return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 16'hA5C3;
  endfunction

  task automatic compare();
    logic er, eq, ek, ed;
    eq = t_act && !t_mmio && cyc >= t_n && (t_e == 0 || cyc < t_e);
    er = t_act && (t_mmio ? (cyc == t_n) : (t_e != 0 && cyc == t_e));
    ek = er && t_mmio && !t_wr && t_addr == 16'hFE02;
    ed = er && t_mmio && t_wr && t_addr == 16'hFE06;
    check("mem_req", 16'(m0.mem_req), 16'(eq));
    check("mem_we", 16'(m0.mem_we), 16'(eq && t_wr));
    check("r", 16'(r), 16'(er));
    check("kbd_ack", 16'(kbd_ack), 16'(ek));
    check("ddr_wr", 16'(ddr_wr), 16'(ed));
    check("mar", mar_out, model_mar);
    check("mdr", mdr_out, model_mdr);
    check("mem_addr", m0.mem_addr, model_mar);
    check("mem_wdata", m0.mem_wdata, model_mdr);
    check("ddr_data", 16'(ddr_data), 16'(model_mdr[7:0]));
    if (m0.mem_req) obs_req++;
    if (r) begin obs_r++; obs_r_cyc = cyc; end
    if (kbd_ack) obs_kack++;
    if (ddr_wr) begin obs_ddr++; cap_ddr = ddr_data; end
  endtask

  // memory side: answer after t_k MEM cycles, junk otherwise
  task automatic respond();
    if (t_act && !t_mmio && t_e == 0 && cyc >= t_n) begin
      if (cyc == t_n + t_k - 1) begin
        m0.mem_rdy = 1'b1;
        t_e = cyc + 1;
        cap_addr = m0.mem_addr;
        cap_wdata = m0.mem_wdata;
        cap_we = m0.mem_we;
        if (t_wr) begin
          mem_model[t_addr] = model_mdr;
          m0.mem_rdata = 16'($urandom);
        end else begin
          m0.mem_rdata = mem_rd(t_addr);
          p_mdr_v = 1'b1;
          p_mdr = mem_rd(t_addr);
        end
      end else begin
        m0.mem_rdy = 1'b0;
        m0.mem_rdata = 16'($urandom);
      end
    end else begin
      m0.mem_rdy = 1'($urandom);
      m0.mem_rdata = 16'($urandom);
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
    cyc++;
    if (p_mar_v) model_mar = p_mar;
    if (p_mdr_v) model_mdr = p_mdr;
    p_mar_v = 1'b0;
    p_mdr_v = 1'b0;
    respond();
  endtask

  task automatic access(input logic [15:0] a, input logic [15:0] d,
                        input logic wr, input int k, input int hold,
                        input logic junk);
    int rc;
    ld_mar = 1'b1; bus_in = a; p_mar_v = 1'b1; p_mar = a;
    step();
    ld_mar = 1'b0;
    if (wr) begin
      ld_mdr = 1'b1; bus_in = d; p_mdr_v = 1'b1; p_mdr = d;
      step();
      ld_mdr = 1'b0;
    end
    bus_in = 16'($urandom);
    obs_req = 0; obs_r = 0; obs_kack = 0; obs_ddr = 0;
    obs_r_cyc = -1; cap_ddr = 8'h00; cap_we = 1'b0;
    cap_addr = 16'h0; cap_wdata = 16'h0;
    mio_en = 1'b1; r_w = wr;
    t_act = 1'b1; t_n = cyc + 1; t_e = 0; t_k = k;
    t_wr = wr; t_addr = a; t_mmio = is_mmio(a);
    if (t_mmio && !wr) begin p_mdr_v = 1'b1; p_mdr = mmio_rd(a); end
    rc = t_mmio ? t_n : t_n + k;
    while (cyc < rc + hold) begin
      step();
      if (junk) begin
        ld_mar = 1'($urandom); ld_mdr = 1'($urandom);
        bus_in = 16'($urandom);
      end
    end
    mio_en = 1'b0; ld_mar = 1'b0; ld_mdr = 1'b0;
    step();
    step();
  endtask

  initial begin
    rst = 1'b1;
    {ld_mar, ld_mdr, mio_en, r_w} = '0;
    bus_in = '0;
    {ld_mar1, ld_mdr1, mio1, rw1} = '0;
    bus1 = '0;
    kbd_valid = 1'b0; kbd_data = 8'h00; dsp_rdy = 1'b0;
    m0.mem_rdy = 1'b0; m0.mem_rdata = '0;
    m1.mem_rdy = 1'b0; m1.mem_rdata = '0;
    model_mar = '0; model_mdr = '0;
    p_mar_v = 1'b0; p_mdr_v = 1'b0; p_mar = '0; p_mdr = '0;
    t_act = 1'b0; t_mmio = 1'b0; t_wr = 1'b0; t_addr = '0;
    t_n = 0; t_e = 0; t_k = 1;
    obs_req = 0; obs_r = 0; obs_kack = 0; obs_ddr = 0; obs_r_cyc = -1;
    cap_ddr = '0; cap_addr = '0; cap_wdata = '0; cap_we = 1'b0;

    step();
    step();
    check("rst_mar", mar_out, 16'h0000);
    check("rst_mdr", mdr_out, 16'h0000);
    check("rst_ddr_data", 16'(ddr_data), 16'h0000);
    rst = 1'b0;
    step();

    mem_model[16'h3000] = 16'hBEEF;
    access(16'h3000, 16'h0, 1'b0, 3, 0, 1'b0);
    check("rd3_mdr", mdr_out, 16'hBEEF);
    check("rd3_req_cycles", 16'(obs_req), 16'd3);
    check("rd3_r_pulses", 16'(obs_r), 16'd1);
    check("rd3_r_lat", 16'(obs_r_cyc - t_n), 16'd3);

    access(16'h4000, 16'h1234, 1'b1, 1, 0, 1'b0);
    check("wr0_addr", cap_addr, 16'h4000);
    check("wr0_wdata", cap_wdata, 16'h1234);
    check("wr0_we", 16'(cap_we), 16'd1);
    check("wr0_r_lat", 16'(obs_r_cyc - t_n), 16'd1);

    kbd_data = 8'h41; kbd_valid = 1'b0;
    access(16'hFE02, 16'h0, 1'b0, 1, 0, 1'b0);
    check("kbdr_mdr", mdr_out, 16'h0041);
    check("kbdr_req", 16'(obs_req), 16'd0);
    check("kbdr_ack", 16'(obs_kack), 16'd1);
    check("kbdr_r_lat", 16'(obs_r_cyc - t_n), 16'd0);

    kbd_valid = 1'b1;
    access(16'hFE00, 16'h0, 1'b0, 1, 0, 1'b0);
    check("kbsr_mdr", mdr_out, 16'h8000);
    check("kbsr_ack", 16'(obs_kack), 16'd0);

    access(16'hFE06, 16'h0058, 1'b1, 1, 0, 1'b0);
    check("ddr_pulses", 16'(obs_ddr), 16'd1);
    check("ddr_char", 16'(cap_ddr), 16'h0058);
    check("ddr_req", 16'(obs_req), 16'd0);

    ld_mar1 = 1'b1; bus1 = 16'hFE06;
    step();
    ld_mar1 = 1'b0; ld_mdr1 = 1'b1; bus1 = 16'h0058;
    step();
    ld_mdr1 = 1'b0; mio1 = 1'b1; rw1 = 1'b1; m1.mem_rdy = 1'b1;
    step();
    check("nommio_req", 16'(m1.mem_req), 16'd1);
    check("nommio_we", 16'(m1.mem_we), 16'd1);
    check("nommio_addr", m1.mem_addr, 16'hFE06);
    check("nommio_wdata", m1.mem_wdata, 16'h0058);
    check("nommio_r_early", 16'(r1), 16'd0);
    step();
    check("nommio_r", 16'(r1), 16'd1);
    check("nommio_ddr_wr", 16'(ddr_wr1), 16'd0);
    mio1 = 1'b0; m1.mem_rdy = 1'b0;
    step();
    check("nommio_r_once", 16'(r1), 16'd0);
    step();

    access(16'h6000, 16'h0, 1'b0, 2, 5, 1'b1);
    check("hold_r_pulses", 16'(obs_r), 16'd1);
    check("hold_req_cycles", 16'(obs_req), 16'd2);
    check("hold_mar", mar_out, 16'h6000);

    mem_model[16'h5000] = 16'hCAFE;
    ld_mar = 1'b1; bus_in = 16'h5000; p_mar_v = 1'b1; p_mar = 16'h5000;
    step();
    ld_mar = 1'b0; mio_en = 1'b1; r_w = 1'b0;
    t_act = 1'b1; t_mmio = 1'b0; t_wr = 1'b0; t_addr = 16'h5000;
    t_n = cyc + 1; t_e = 0; t_k = 20;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    check("rstmid_req", 16'(m0.mem_req), 16'd0);
    check("rstmid_r", 16'(r), 16'd0);
    check("rstmid_mar", mar_out, 16'h0000);
    check("rstmid_mdr", mdr_out, 16'h0000);
    mio_en = 1'b0; t_act = 1'b0;
    model_mar = '0; model_mdr = '0; p_mar_v = 1'b0; p_mdr_v = 1'b0;
    step();
    rst = 1'b0;
    step();
    obs_r = 0;
    access(16'h5000, 16'h0, 1'b0, 2, 0, 1'b0);
    check("post_rst_mdr", mdr_out, 16'hCAFE);
    check("post_rst_r", 16'(obs_r), 16'd1);

    for (int i = 0; i < 150; i++) begin
      logic [15:0] a;
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 3) a = 16'hFE00 + 16'(2 * $urandom_range(0, 3));
      else a = 16'($urandom);
      kbd_valid = 1'($urandom);
      kbd_data = 8'($urandom);
      dsp_rdy = 1'($urandom);
      access(a, 16'($urandom), 1'($urandom),
             int'($urandom_range(1, 4)), int'($urandom_range(0, 3)),
             1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
